lcd_bus_sink: RTL

Receiving end of the character-LCD write bus produced by the team's display drivers (`lcd_en`, `lcd_rs`, `lcd_rw`, `lcd_db`, `lcd_rst`).
- Decodes each write strobe into a data write or a controller command.
- Stores characters in a 2-row × 32-column character RAM with an auto-incrementing cursor.
- Exposes the RAM through a 1-cycle readback port.
- Used as an on-chip panel model for checking display drivers and as a mirror of panel contents for debug logic.

---
 rtl/lcd_bus_sink_if.sv | 22 ++
 rtl/lcd_bus_sink.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_sink_if.sv
// -----------------------------------------------------------------------------
// lcd_bus_sink_if
// Character-LCD write bus between a display driver and its sink.
//   lcd_en  : write enable; a strobe is its falling edge as seen by the sink
//   lcd_rs  : 0 = command, 1 = data
//   lcd_rw  : 0 = write, 1 = read (reads are not supported by the sink)
//   lcd_db  : 8-bit bus data
//   lcd_rst : panel reset, active-high, synchronous to the sink clock
// Modports: master = driver side, slave = sink side.
// -----------------------------------------------------------------------------
interface lcd_bus_sink_if;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_db;
    logic       lcd_rst;

    modport master (output lcd_en, output lcd_rs, output lcd_rw,
                    output lcd_db, output lcd_rst);
    modport slave  (input  lcd_en, input  lcd_rs, input  lcd_rw,
                    input  lcd_db, input  lcd_rst);
endinterface

// File: rtl/lcd_bus_sink.sv
// -----------------------------------------------------------------------------
// lcd_bus_sink
// Receiving end of the character-LCD write bus. Decodes write strobes into
// data writes or controller commands, stores characters in a 2 x 32 character
// RAM (row 0 = addresses 0..31, row 1 = 32..63 at the default ADDR_W) with an
// auto-incrementing cursor, and exposes the RAM through a 1-cycle readback.
//
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : synchronous reset, ACTIVE-HIGH despite the name (high = reset)
//   bus        : lcd_bus_sink_if.slave (lcd_en, lcd_rs, lcd_rw, lcd_db, lcd_rst)
//   rd_addr    : readback address
//   rd_data    : RAM contents at rd_addr sampled on the previous edge
//   cursor     : current write address
//   busy       : clear sequence in progress
//   wr_pulse   : one-cycle pulse per accepted data write
//   frame_done : one-cycle pulse when the cursor wraps to 0 on a data write
//   err        : sticky dropped-strobe flag, cleared only by rst_n
//
// Build option:
//   LCD_SINK_CMD_EN : when defined, command strobes are decoded in IDLE
//                     (0x01 clear, 0x02 home, 0x80|a set cursor, others err).
//                     When undefined, command strobes are silently ignored.
// -----------------------------------------------------------------------------
module lcd_bus_sink #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    lcd_bus_sink_if.slave     bus,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [ADDR_W-1:0] cursor,
    output logic              busy,
    output logic              wr_pulse,
    output logic              frame_done,
    output logic              err
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;

    logic              en_q_r;
    logic [ADDR_W-1:0] clr_addr_r;
    logic [ADDR_W-1:0] cursor_r;
    logic              busy_r;
    logic              wr_pulse_r;
    logic              frame_done_r;
    logic              err_r;
    logic [7:0]        rd_data_r;
    logic [7:0]        mem_r [DEPTH];

    logic              strobe_s;
    logic              any_rst_s;
    logic              read_s;
    logic              data_wr_s;
    logic              cmd_clear_s;
    logic              cmd_home_s;
    logic              cmd_addr_s;
    logic              cmd_bad_s;
    logic [ADDR_W-1:0] cmd_addr_val_s;

    logic              ram_we_s;
    logic [ADDR_W-1:0] ram_wa_s;
    logic [7:0]        ram_wd_s;
    logic [ADDR_W-1:0] clr_addr_nxt_s;
    logic [ADDR_W-1:0] cursor_nxt_s;
    logic              wr_pulse_nxt_s;
    logic              frame_done_nxt_s;
    logic              err_set_s;

    // Strobe = falling edge of lcd_en; bus fields are taken in the same cycle.
    assign strobe_s  = en_q_r & ~bus.lcd_en;
    assign any_rst_s = rst_n | bus.lcd_rst;
    assign read_s    = strobe_s &  bus.lcd_rw;
    assign data_wr_s = strobe_s & ~bus.lcd_rw &  bus.lcd_rs;

`ifdef LCD_SINK_CMD_EN
    logic cmd_s;
    assign cmd_s          = strobe_s & ~bus.lcd_rw & ~bus.lcd_rs;
    assign cmd_clear_s    = cmd_s & (bus.lcd_db == 8'h01);
    assign cmd_home_s     = cmd_s & (bus.lcd_db == 8'h02);
    // 0x80..0xBF: set cursor to the low six bits.
    assign cmd_addr_s     = cmd_s & (bus.lcd_db[7:6] == 2'b10);
    assign cmd_bad_s      = cmd_s & ~cmd_clear_s & ~cmd_home_s & ~cmd_addr_s;
    assign cmd_addr_val_s = ADDR_W'(bus.lcd_db[5:0]);
`else
    // Data-only sink: command strobes cause no state change and no error.
    assign cmd_clear_s    = 1'b0;
    assign cmd_home_s     = 1'b0;
    assign cmd_addr_s     = 1'b0;
    assign cmd_bad_s      = 1'b0;
    assign cmd_addr_val_s = ADDR_ZERO;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_r <= ST_CLEAR;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: either reset source restarts the clear from any state.
    always_comb begin
        state_nxt_s = state_r;
        if (any_rst_s) begin
            state_nxt_s = ST_CLEAR;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (clr_addr_r == ADDR_MAX) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_CLEAR;
                    end
                end
                ST_IDLE: begin
                    if (cmd_clear_s) begin
                        state_nxt_s = ST_CLEAR;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                default: state_nxt_s = ST_CLEAR;
            endcase
        end
    end

    // Output/datapath decode: RAM write port and next values of registered outputs.
    always_comb begin
        ram_we_s         = 1'b0;
        ram_wa_s         = cursor_r;
        ram_wd_s         = bus.lcd_db;
        clr_addr_nxt_s   = clr_addr_r;
        cursor_nxt_s     = cursor_r;
        wr_pulse_nxt_s   = 1'b0;
        frame_done_nxt_s = 1'b0;
        err_set_s        = 1'b0;
        if (any_rst_s) begin
            // Strobes coinciding with a reset are discarded without error.
            clr_addr_nxt_s = ADDR_ZERO;
            cursor_nxt_s   = ADDR_ZERO;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    ram_we_s       = 1'b1;
                    ram_wa_s       = clr_addr_r;
                    ram_wd_s       = 8'h00;
                    clr_addr_nxt_s = clr_addr_r + ADDR_ONE;
                    cursor_nxt_s   = ADDR_ZERO;
                    err_set_s      = strobe_s;
                end
                ST_IDLE: begin
                    if (read_s) begin
                        err_set_s = 1'b1;
                    end else if (data_wr_s) begin
                        ram_we_s         = 1'b1;
                        ram_wa_s         = cursor_r;
                        ram_wd_s         = bus.lcd_db;
                        cursor_nxt_s     = cursor_r + ADDR_ONE;
                        wr_pulse_nxt_s   = 1'b1;
                        frame_done_nxt_s = (cursor_r == ADDR_MAX);
                    end else if (cmd_clear_s) begin
                        clr_addr_nxt_s = ADDR_ZERO;
                        cursor_nxt_s   = ADDR_ZERO;
                    end else if (cmd_home_s) begin
                        cursor_nxt_s = ADDR_ZERO;
                    end else if (cmd_addr_s) begin
                        cursor_nxt_s = cmd_addr_val_s;
                    end else if (cmd_bad_s) begin
                        err_set_s = 1'b1;
                    end else begin
                        cursor_nxt_s = cursor_r;
                    end
                end
                default: begin
                    clr_addr_nxt_s = ADDR_ZERO;
                    cursor_nxt_s   = ADDR_ZERO;
                end
            endcase
        end
    end

    // Registered outputs, strobe edge detector and readback; err survives lcd_rst.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            en_q_r       <= 1'b0;
            clr_addr_r   <= ADDR_ZERO;
            cursor_r     <= ADDR_ZERO;
            busy_r       <= 1'b1;
            wr_pulse_r   <= 1'b0;
            frame_done_r <= 1'b0;
            err_r        <= 1'b0;
            rd_data_r    <= 8'h00;
        end else begin
            en_q_r       <= bus.lcd_en;
            clr_addr_r   <= clr_addr_nxt_s;
            cursor_r     <= cursor_nxt_s;
            busy_r       <= (state_nxt_s == ST_CLEAR);
            wr_pulse_r   <= wr_pulse_nxt_s;
            frame_done_r <= frame_done_nxt_s;
            err_r        <= err_r | err_set_s;
            // Read-before-write: a same-cycle write to rd_addr shows up next read.
            rd_data_r    <= mem_r[rd_addr];
        end
    end

    // Character RAM write port; contents are initialised by the clear sequence.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem_r[ram_wa_s] <= ram_wd_s;
        end
    end

    assign rd_data    = rd_data_r;
    assign cursor     = cursor_r;
    assign busy       = busy_r;
    assign wr_pulse   = wr_pulse_r;
    assign frame_done = frame_done_r;
    assign err        = err_r;

endmodule
